// File: rtl/vga_scanout.sv
// 640x480@60 raster timing plus frame-buffer read pipeline (2x scaled 256x240 image, centred).
// Optional build macro VGA_SCANLINE_EN halves in-window colour on odd output lines.
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned X_OFFSET   = 64,
  parameter logic [8:0]  BORDER_RGB = 9'h000
) (
  input  logic       pix_clk,
  input  logic       rst,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  logic [8:0] rgb_in,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned IMG_W   = 512;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_START    = HW'(X_OFFSET);
  localparam logic [HW-1:0] X_END      = HW'(X_OFFSET + IMG_W);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: raster counters and the terms derived from them.
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [HW-1:0] h_off;
  logic          v_active, in_win;
  logic          hsync_raw, vsync_raw, vblank_raw, fs_raw;

  // Stage 1: control delayed to line up with the frame buffer's registered read data.
  logic in_win_d1_q, hsync_d1_q, vsync_d1_q, vblank_d1_q, fs_d1_q;

  // Stage 2: output registers.
  logic [8:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q, vblank_q, fs_q;

`ifdef VGA_SCANLINE_EN
  logic odd_d1_q;
`endif

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  assign v_active   = (v_cnt_q < V_ACT);
  assign in_win     = (h_cnt_q >= X_START) && (h_cnt_q < X_END) && v_active;
  assign h_off      = h_cnt_q - X_START;
  assign pix_ptr_x  = in_win   ? 8'(h_off >> 1)   : 8'd0;
  assign pix_ptr_y  = v_active ? 8'(v_cnt_q >> 1) : 8'd0;
  assign hsync_raw  = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
  assign vsync_raw  = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
  assign vblank_raw = !v_active;
  assign fs_raw     = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

  always_comb begin
    rgb_d = BORDER_RGB;
    if (in_win_d1_q) begin
      rgb_d = rgb_in;
`ifdef VGA_SCANLINE_EN
      if (odd_d1_q) rgb_d = {1'b0, rgb_in[8:7], 1'b0, rgb_in[5:4], 1'b0, rgb_in[2:1]};
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      in_win_d1_q <= 1'b0;
      hsync_d1_q  <= 1'b1;
      vsync_d1_q  <= 1'b1;
      vblank_d1_q <= 1'b0;
      fs_d1_q     <= 1'b0;
      rgb_q       <= 9'h000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      vblank_q    <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      in_win_d1_q <= in_win;
      hsync_d1_q  <= hsync_raw;
      vsync_d1_q  <= vsync_raw;
      vblank_d1_q <= vblank_raw;
      fs_d1_q     <= fs_raw;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d1_q;
      vsync_q     <= vsync_d1_q;
      vblank_q    <= vblank_d1_q;
      fs_q        <= fs_d1_q;
    end
  end

`ifdef VGA_SCANLINE_EN
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) odd_d1_q <= 1'b0;
    else     odd_d1_q <= v_cnt_q[0];
  end
`endif

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-size instance A plus a short-frame instance B (same horizontal
// timing, small vertical totals) so whole frames fit in a short run; both checked every cycle.
module tb_vga_scanout;

  localparam int HT    = 800;
  localparam int VA_A  = 480, VFP_A = 10, VS_A = 2, VT_A = 525;
  localparam int VA_B  = 20,  VFP_B = 3,  VS_B = 2, VT_B = 29;
  localparam int FRAME_B = HT * VT_B;

  logic       pix_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] px_a, py_a, px_b, py_b;
  logic [8:0] rgb_in_a = '0, rgb_in_b = '0;
  logic [2:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, vb_a, fs_a, hs_b, vs_b, vb_b, fs_b;

  vga_scanout u_a (
    .pix_clk(pix_clk), .rst(rst), .pix_ptr_x(px_a), .pix_ptr_y(py_a), .rgb_in(rgb_in_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hsync(hs_a), .vsync(vs_a), .vblank(vb_a),
    .frame_start(fs_a)
  );

  vga_scanout #(.V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VS_B), .V_BP(4)) u_b (
    .pix_clk(pix_clk), .rst(rst), .pix_ptr_x(px_b), .pix_ptr_y(py_b), .rgb_in(rgb_in_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync(hs_b), .vsync(vs_b), .vblank(vb_b),
    .frame_start(fs_b)
  );

  always #5 pix_clk = ~pix_clk;

  // Frame buffer model: registered read of the address presented in the previous cycle.
  logic [8:0] fb_mem [0:239][0:255];
  logic [7:0] sx_a, sy_a, sx_b, sy_b;

  always @(negedge pix_clk) begin
    sx_a = px_a; sy_a = py_a; sx_b = px_b; sy_b = py_b;
  end

  always @(posedge pix_clk) begin
    #1;
    rgb_in_a = fb_mem[sy_a][sx_a];
    rgb_in_b = fb_mem[sy_b][sx_b];
  end

  int n;
  int checks = 0, errors = 0;
  int first_hs_a, hs_low_a, vs_low_b, vb_hi_b, fs_cnt_b, fs_cnt_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Colour the monitor should show for raster position (h, v).
  function automatic logic [8:0] exp_colour(input int h, input int v, input int va);
    logic [8:0] c;
    if (h >= 64 && h < 576 && v < va) begin
      c = fb_mem[v / 2][(h - 64) / 2];
`ifdef VGA_SCANLINE_EN
      if (v % 2 == 1) c = {1'b0, c[8:7], 1'b0, c[5:4], 1'b0, c[2:1]};
`endif
      return c;
    end
    return 9'h000;
  endfunction

  task automatic check_inst(input string nm, input int va, input int vfp, input int vsw,
                            input int vt, input logic [7:0] px, input logic [7:0] py,
                            input logic [8:0] rgb, input logic hs, input logic vs,
                            input logic vb, input logic fs);
    int h, v, pos;
    h = n % HT;
    v = (n / HT) % vt;
    check({nm, ".ptr_x"}, 32'(px), (h >= 64 && h < 576 && v < va) ? 32'((h - 64) / 2) : 32'd0);
    check({nm, ".ptr_y"}, 32'(py), (v < va) ? 32'(v / 2) : 32'd0);
    if (n < 2) begin
      check({nm, ".rgb"}, 32'(rgb), 32'd0);
      check({nm, ".hsync"}, 32'(hs), 32'd1);
      check({nm, ".vsync"}, 32'(vs), 32'd1);
      check({nm, ".vblank"}, 32'(vb), 32'd0);
      check({nm, ".fstart"}, 32'(fs), 32'd0);
    end else begin
      pos = n - 2;
      h = pos % HT;
      v = (pos / HT) % vt;
      check({nm, ".rgb"}, 32'(rgb), 32'(exp_colour(h, v, va)));
      check({nm, ".hsync"}, 32'(hs), (h >= 656 && h < 752) ? 32'd0 : 32'd1);
      check({nm, ".vsync"}, 32'(vs), (v >= va + vfp && v < va + vfp + vsw) ? 32'd0 : 32'd1);
      check({nm, ".vblank"}, 32'(vb), (v >= va) ? 32'd1 : 32'd0);
      check({nm, ".fstart"}, 32'(fs), (h == 0 && v == va) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst.rgb_a", 32'({r_a, g_a, b_a}), 32'd0);
    check("rst.rgb_b", 32'({r_b, g_b, b_b}), 32'd0);
    check("rst.hsync_a", 32'(hs_a), 32'd1);
    check("rst.vsync_a", 32'(vs_a), 32'd1);
    check("rst.vblank_b", 32'(vb_b), 32'd0);
    check("rst.fstart_b", 32'(fs_b), 32'd0);
    check("rst.ptr_y_a", 32'(py_a), 32'd0);
    check("rst.ptr_x_a", 32'(px_a), 32'd0);
  endtask

  task automatic clear_stats();
    n = 0; first_hs_a = -1; hs_low_a = 0; vs_low_b = 0; vb_hi_b = 0; fs_cnt_b = 0; fs_cnt_a = 0;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge pix_clk);
      n++;
      @(negedge pix_clk);
      check_inst("A", VA_A, VFP_A, VS_A, VT_A, px_a, py_a, {r_a, g_a, b_a}, hs_a, vs_a, vb_a, fs_a);
      check_inst("B", VA_B, VFP_B, VS_B, VT_B, px_b, py_b, {r_b, g_b, b_b}, hs_b, vs_b, vb_b, fs_b);
      if (!hs_a && first_hs_a < 0) first_hs_a = n;
      if (!hs_a && n >= 2 && n < 2 + HT) hs_low_a++;
      if (fs_a) fs_cnt_a++;
      if (n >= 2 && n < 2 + 2 * FRAME_B) begin
        if (!vs_b) vs_low_b++;
        if (vb_b) vb_hi_b++;
        if (fs_b) fs_cnt_b++;
      end
    end
  endtask

  initial begin
    // Rows cycle through: colour = column, all-ones, random.
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 256; x++)
        case (y % 3)
          0:       fb_mem[y][x] = 9'(x);
          1:       fb_mem[y][x] = 9'h1FF;
          default: fb_mem[y][x] = 9'($urandom_range(511));
        endcase

    clear_stats();
    repeat (3) @(negedge pix_clk);
    check_reset_outputs();
    rst = 1'b0;
    clear_stats();

    // Run up to raster position (h=300, v=10), then reset mid-line.
    run(10 * HT + 300);
    check("first_hsync_fall", 32'(first_hs_a), 32'd658);
    check("hsync_low_width", 32'(hs_low_a), 32'd96);

    #1 rst = 1'b1;
    #1 check_reset_outputs();
    repeat (3) @(negedge pix_clk);
    check_reset_outputs();
    rst = 1'b0;
    clear_stats();

    run(2 * FRAME_B + 900);
    check("post_rst_hsync_fall", 32'(first_hs_a), 32'd658);
    check("post_rst_hsync_width", 32'(hs_low_a), 32'd96);
    check("B.vsync_low_2fr", 32'(vs_low_b), 32'(2 * VS_B * HT));
    check("B.vblank_hi_2fr", 32'(vb_hi_b), 32'(2 * (VT_B - VA_B) * HT));
    check("B.fstart_2fr", 32'(fs_cnt_b), 32'd2);
    check("A.no_fstart", 32'(fs_cnt_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
